// File: rtl/ao_ch_pkg.sv
// Shared types and constants for the AO channel controller and its SPI timing.
package ao_ch_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DA_SETUP,
    ST_DA_SHIFT,
    ST_DA_HOLD,
    ST_GAP,
    ST_AD_SETUP,
    ST_AD_SHIFT,
    ST_AD_HOLD,
    ST_DONE
  } state_t;

  localparam logic [31:0] DA_HDR_DEF   = 32'h5500_0001;
  localparam logic [7:0]  AD_CMD_DEF   = 8'h58;
  localparam int          DA_BITS      = 48;
  localparam int          AD_CMD_BITS  = 8;
  localparam int          AD_DATA_BITS = 16;
  localparam int          AD_BITS      = AD_CMD_BITS + AD_DATA_BITS;
  localparam int          HALF_W       = 7;

  // Half-periods spent in a phase, minus one. Shift phases span first rise to
  // last fall; AD_HOLD carries two extra CS-high half-periods before DONE.
  function automatic logic [HALF_W-1:0] phase_halves(input state_t st);
    logic [HALF_W-1:0] n;
    n = '0;
    case (st)
      ST_DA_SHIFT: n = HALF_W'(2 * DA_BITS - 2);
      ST_DA_HOLD:  n = HALF_W'(1);
      ST_GAP:      n = HALF_W'(1);
      ST_AD_SHIFT: n = HALF_W'(2 * AD_BITS - 2);
      ST_AD_HOLD:  n = HALF_W'(3);
      default:     n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: terminal-count strobe every CLK_DIV cycles while enabled,
// toggling SCLK on strobes when i_tog is set. Shared by the DA and AD links.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_tog,
  output logic o_sclk,
  output logic o_tc,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  assign o_tc   = i_en && (r_cnt == '0);
  assign o_rise = o_tc && i_tog && !r_sclk;
  assign o_fall = o_tc && i_tog && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= RELOAD;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= RELOAD;
      r_sclk <= 1'b0;
    end else if (o_tc) begin
      r_cnt <= RELOAD;
      if (i_tog) r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ao_ch_ctrl.sv
// AO channel SPI master: DA write frame, optional AD readback and compare.
// Readback is built only when AO_CH_READBACK_EN is defined.
module ao_ch_ctrl
  import ao_ch_pkg::*;
#(
  parameter int          CLK_DIV = 4,
  parameter logic [31:0] DA_HDR  = DA_HDR_DEF,
  parameter logic [7:0]  AD_CMD  = AD_CMD_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_req,
  input  logic [15:0] i_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_cmp_err,
  output logic        o_da_spi_clk,
  output logic        o_da_spi_cs,
  output logic        o_da_spi_mosi,
  output logic        o_ad_spi_clk,
  output logic        o_ad_spi_cs,
  output logic        o_ad_spi_mosi,
  input  logic        i_ad_spi_miso
);

  // state     | meaning
  // DA_*      | DA frame: CS-low setup, 48 SCLK cycles, CS-high hold
  // GAP/AD_*  | both links idle, then the 24-cycle AD readback frame
  // DONE      | one-cycle completion pulse, back to IDLE
  state_t            r_state, w_state_nxt;
  logic [HALF_W-1:0] r_half;
  logic              w_accept, w_en, w_tog, w_tc, w_rise, w_fall, w_sclk, w_last;
  logic              r_busy, r_done, r_da_cs;
  logic [DA_BITS-1:0] r_sr;
  logic              w_ad_link;

  assign w_accept = i_wr_req && (r_state == ST_IDLE);
  assign w_en     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_tog    = r_state inside {ST_DA_SETUP, ST_DA_SHIFT, ST_AD_SETUP, ST_AD_SHIFT};
  assign w_last   = w_tc && (r_half == '0);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en),
    .i_tog   (w_tog),
    .o_sclk  (w_sclk),
    .o_tc    (w_tc),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_state_nxt = ST_DA_SETUP;
      ST_DA_SETUP: if (w_last)   w_state_nxt = ST_DA_SHIFT;
      ST_DA_SHIFT: if (w_last)   w_state_nxt = ST_DA_HOLD;
`ifdef AO_CH_READBACK_EN
      ST_DA_HOLD:  if (w_last)   w_state_nxt = ST_GAP;
`else
      ST_DA_HOLD:  if (w_last)   w_state_nxt = ST_DONE;
`endif
      ST_GAP:      if (w_last)   w_state_nxt = ST_AD_SETUP;
      ST_AD_SETUP: if (w_last)   w_state_nxt = ST_AD_SHIFT;
      ST_AD_SHIFT: if (w_last)   w_state_nxt = ST_AD_HOLD;
      ST_AD_HOLD:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_half <= '0;
    else if (w_state_nxt != r_state)  r_half <= phase_halves(w_state_nxt);
    else if (w_tc)                    r_half <= r_half - 1'b1;
  end

  // The frame MSB is on r_sr[47]; each falling edge advances to the next bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_da_cs <= 1'b1;
      r_sr    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_da_cs <= 1'b0;
        r_sr    <= {DA_HDR, i_wr_data};
      end
      if ((r_state == ST_DA_HOLD) && w_tc && (r_half == HALF_W'(1))) r_da_cs <= 1'b1;
      if (w_fall) r_sr <= {r_sr[DA_BITS-2:0], 1'b0};
`ifdef AO_CH_READBACK_EN
      if ((r_state == ST_GAP) && w_last)
        r_sr <= {AD_CMD, {(DA_BITS - AD_CMD_BITS){1'b0}}};
`endif
      if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

`ifdef AO_CH_READBACK_EN
  logic                    r_ad_link, r_ad_cs, r_rd_valid, r_cmp_err;
  logic [AD_DATA_BITS-1:0] r_code, r_rx, r_rd_data;

  // r_rx keeps the last 16 MISO bits, which are exactly frame cycles 9..24.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ad_link  <= 1'b0;
      r_ad_cs    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_cmp_err  <= 1'b0;
      r_code     <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_code    <= i_wr_data;
        r_cmp_err <= 1'b0;
      end
      if ((r_state == ST_DA_HOLD) && w_last) r_ad_link <= 1'b1;
      if ((r_state == ST_GAP) && w_last)     r_ad_cs   <= 1'b0;
      if (w_rise && r_ad_link)               r_rx      <= {r_rx[AD_DATA_BITS-2:0], i_ad_spi_miso};
      if ((r_state == ST_AD_HOLD) && w_tc && (r_half == HALF_W'(3))) r_ad_cs <= 1'b1;
      if (r_state == ST_DONE) begin
        r_ad_link  <= 1'b0;
        r_rd_data  <= r_rx;
        r_rd_valid <= 1'b1;
        if (r_rx[AD_DATA_BITS-1:1] != r_code[AD_DATA_BITS-1:1]) r_cmp_err <= 1'b1;
      end
    end
  end

  assign w_ad_link     = r_ad_link;
  assign o_ad_spi_clk  = w_sclk & r_ad_link;
  assign o_ad_spi_cs   = r_ad_cs;
  assign o_ad_spi_mosi = r_sr[DA_BITS-1] & r_ad_link;
  assign o_rd_data     = r_rd_data;
  assign o_rd_valid    = r_rd_valid;
  assign o_cmp_err     = r_cmp_err;
`else
  logic w_unused;
  assign w_unused      = ^{i_ad_spi_miso, w_rise};
  assign w_ad_link     = 1'b0;
  assign o_ad_spi_clk  = 1'b0;
  assign o_ad_spi_cs   = 1'b1;
  assign o_ad_spi_mosi = 1'b0;
  assign o_rd_data     = '0;
  assign o_rd_valid    = 1'b0;
  assign o_cmp_err     = 1'b0;
`endif

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_da_spi_clk  = w_sclk & ~w_ad_link;
  assign o_da_spi_cs   = r_da_cs;
  assign o_da_spi_mosi = r_sr[DA_BITS-1] & ~w_ad_link;

endmodule

// File: tb/tb_ao_ch_ctrl.sv
// Self-checking bench for ao_ch_ctrl with DAC/ADC slave models (AO_CH_READBACK_EN aware).
module tb_ao_ch_ctrl;

  localparam int CLK_DIV = 4;
`ifdef AO_CH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int          LAT = RB ? (152 * CLK_DIV + 2) : (98 * CLK_DIV + 2);
  localparam logic [31:0] HDR = 32'h5500_0001;
  localparam logic [7:0]  CMD = 8'h58;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_wr_req = 1'b0, miso = 1'b0;
  logic [15:0] i_wr_data = '0;
  logic        o_busy, o_done, o_rd_valid, o_cmp_err;
  logic [15:0] o_rd_data;
  logic        o_da_spi_clk, o_da_spi_cs, o_da_spi_mosi;
  logic        o_ad_spi_clk, o_ad_spi_cs, o_ad_spi_mosi;

  int checks = 0, failures = 0;

  always #5 i_clk = ~i_clk;

  ao_ch_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_req(i_wr_req), .i_wr_data(i_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_cmp_err(o_cmp_err), .o_da_spi_clk(o_da_spi_clk), .o_da_spi_cs(o_da_spi_cs),
    .o_da_spi_mosi(o_da_spi_mosi), .o_ad_spi_clk(o_ad_spi_clk), .o_ad_spi_cs(o_ad_spi_cs),
    .o_ad_spi_mosi(o_ad_spi_mosi), .i_ad_spi_miso(miso)
  );

  // Slave models: DAC captures 48 bits on rises; ADC returns ad_reply MSB first.
  int          da_rises = 0, ad_rises = 0, done_total = 0, ad_cs_falls = 0, ad_idx = 0;
  logic [47:0] da_sh = '0;
  logic [23:0] ad_sh = '0, ad_reply = '0;
  bit          overlap = 1'b0;

  always @(posedge o_da_spi_clk) begin
    da_rises++;
    da_sh = {da_sh[46:0], o_da_spi_mosi};
  end
  always @(posedge o_ad_spi_clk) begin
    ad_rises++;
    ad_sh = {ad_sh[22:0], o_ad_spi_mosi};
  end
  always @(negedge o_ad_spi_cs) begin
    ad_cs_falls++;
    ad_idx = 23;
    miso = ad_reply[23];
  end
  always @(negedge o_ad_spi_clk) begin
    if (o_ad_spi_cs === 1'b0) begin
      ad_idx--;
      miso = (ad_idx >= 0) ? ad_reply[ad_idx] : 1'b0;
    end
  end
  always @(negedge i_clk) begin
    if (o_done === 1'b1) done_total++;
    if (o_da_spi_cs === 1'b0 && o_ad_spi_cs === 1'b0) overlap = 1'b1;
  end

  // Observations of the last transaction
  int          obs_lat, n_da, n_ad, n_done, n_writes = 0;
  bit          obs_to;
  logic        obs_busy1, obs_cs1, obs_busy_done, obs_rv_done, obs_cmp, obs_busy_after;
  logic [15:0] obs_rd;

  task automatic do_write(input logic [15:0] d, input logic [15:0] reply, input int extra_req_at);
    int  s_da, s_ad, s_done;
    bit  got;
    ad_reply = {8'($urandom_range(0, 255)), reply};
    s_da = da_rises; s_ad = ad_rises; s_done = done_total;
    @(negedge i_clk);
    i_wr_req = 1'b1; i_wr_data = d;
    obs_lat = 0; obs_to = 1'b0; got = 1'b0;
    while (!got && !obs_to) begin
      @(negedge i_clk);
      obs_lat++;
      i_wr_req = (obs_lat == extra_req_at);
      if (obs_lat == extra_req_at) i_wr_data = ~d;
      if (obs_lat == 1) begin obs_busy1 = o_busy; obs_cs1 = o_da_spi_cs; end
      if (o_done === 1'b1) begin
        got = 1'b1;
        obs_busy_done = o_busy; obs_rv_done = o_rd_valid;
        obs_rd = o_rd_data; obs_cmp = o_cmp_err;
      end
      if (obs_lat >= 3000) obs_to = 1'b1;
    end
    i_wr_req = 1'b0;
    repeat (4) @(negedge i_clk);
    obs_busy_after = o_busy;
    n_da = da_rises - s_da; n_ad = ad_rises - s_ad; n_done = done_total - s_done;
    if (got) n_writes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid); end
    checks++; if (o_cmp_err !== 1'b0) begin failures++; $display("FAIL reset_cmp_err got=%b exp=0", o_cmp_err); end
    checks++; if (o_rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", o_rd_data); end
    checks++; if ({o_da_spi_clk, o_da_spi_cs, o_da_spi_mosi} !== 3'b010) begin
      failures++; $display("FAIL reset_da_pins got=%b exp=010", {o_da_spi_clk, o_da_spi_cs, o_da_spi_mosi}); end
    checks++; if ({o_ad_spi_clk, o_ad_spi_cs, o_ad_spi_mosi} !== 3'b010) begin
      failures++; $display("FAIL reset_ad_pins got=%b exp=010", {o_ad_spi_clk, o_ad_spi_cs, o_ad_spi_mosi}); end
  endtask

  task automatic test_directed();
    logic [15:0] dv[4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0002};
    logic [15:0] rv[4] = '{16'h1234, 16'hFFFE, 16'h0000, 16'h0002};
    logic [15:0] e_rd;
    logic        e_cmp;
    for (int i = 0; i < 4; i++) begin
      do_write(dv[i], rv[i], -1);
      e_rd  = RB ? rv[i] : 16'h0;
      e_cmp = RB ? (rv[i][15:1] != dv[i][15:1]) : 1'b0;
      checks++; if (obs_to !== 1'b0 || obs_lat != LAT) begin
        failures++; $display("FAIL dir_latency d=%h got=%0d exp=%0d", dv[i], obs_lat, LAT); end
      checks++; if (obs_busy1 !== 1'b1 || obs_cs1 !== 1'b0) begin
        failures++; $display("FAIL dir_start d=%h busy=%b cs=%b exp busy=1 cs=0", dv[i], obs_busy1, obs_cs1); end
      checks++; if (obs_busy_done !== 1'b0 || obs_rv_done !== RB) begin
        failures++; $display("FAIL dir_done_flags d=%h busy=%b rv=%b exp busy=0 rv=%b", dv[i], obs_busy_done, obs_rv_done, RB); end
      checks++; if (da_sh !== {HDR, dv[i]} || n_da != 48) begin
        failures++; $display("FAIL dir_da_frame d=%h got=%h/%0d exp=%h/48", dv[i], da_sh, n_da, {HDR, dv[i]}); end
      checks++; if (n_ad != (RB ? 24 : 0) || ad_sh !== (RB ? {CMD, 16'h0} : 24'h0)) begin
        failures++; $display("FAIL dir_ad_frame d=%h got=%h/%0d", dv[i], ad_sh, n_ad); end
      checks++; if (obs_rd !== e_rd) begin
        failures++; $display("FAIL dir_rd_data d=%h got=%h exp=%h", dv[i], obs_rd, e_rd); end
      checks++; if (obs_cmp !== e_cmp) begin
        failures++; $display("FAIL dir_cmp_err d=%h got=%b exp=%b", dv[i], obs_cmp, e_cmp); end
      checks++; if (n_done != 1) begin
        failures++; $display("FAIL dir_done_count d=%h got=%0d exp=1", dv[i], n_done); end
    end
  endtask

  task automatic test_random();
    logic [15:0] d, rep, e_rd;
    logic        e_cmp;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rep = {d[15:1], 1'($urandom_range(0, 1))};
      else                           rep = 16'($urandom);
      do_write(d, rep, -1);
      e_rd  = RB ? rep : 16'h0;
      e_cmp = RB ? (rep[15:1] != d[15:1]) : 1'b0;
      checks++; if (obs_lat != LAT || da_sh !== {HDR, d}) begin
        failures++; $display("FAIL rnd_frame d=%h lat=%0d frame=%h", d, obs_lat, da_sh); end
      checks++; if (obs_rd !== e_rd || obs_cmp !== e_cmp) begin
        failures++; $display("FAIL rnd_readback d=%h rd=%h cmp=%b exp rd=%h cmp=%b", d, obs_rd, obs_cmp, e_rd, e_cmp); end
    end
  endtask

  task automatic test_ignore_busy();
    do_write(16'h3C5A, 16'h3C5A, 100);
    checks++; if (n_done != 1 || obs_lat != LAT) begin
      failures++; $display("FAIL busy_ignore_done got=%0d/%0d exp=1/%0d", n_done, obs_lat, LAT); end
    checks++; if (n_da != 48 || da_sh !== {HDR, 16'h3C5A}) begin
      failures++; $display("FAIL busy_ignore_frame got=%h/%0d exp=%h/48", da_sh, n_da, {HDR, 16'h3C5A}); end
    checks++; if (obs_busy_after !== 1'b0) begin
      failures++; $display("FAIL busy_ignore_queued busy=%b exp=0", obs_busy_after); end
  endtask

  task automatic test_reset_mid();
    int          s, n;
    logic [15:0] e_rd;
    s = da_rises; n = 0;
    @(negedge i_clk); i_wr_req = 1'b1; i_wr_data = 16'h4B2D;
    @(negedge i_clk); i_wr_req = 1'b0;
    while ((da_rises - s) < 20 && n < 2000) begin @(negedge i_clk); n++; end
    checks++; if ((da_rises - s) != 20) begin
      failures++; $display("FAIL mid_wait rises=%0d exp=20", da_rises - s); end
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_da_spi_cs, o_da_spi_clk, o_busy} !== 3'b100) begin
      failures++; $display("FAIL mid_reset_pins cs/clk/busy=%b exp=100", {o_da_spi_cs, o_da_spi_clk, o_busy}); end
    @(posedge i_clk); #1;
    checks++; if ({o_da_spi_cs, o_da_spi_clk, o_busy, o_rd_data} !== {3'b100, 16'h0}) begin
      failures++; $display("FAIL mid_reset_hold got=%b/%h exp=100/0000", {o_da_spi_cs, o_da_spi_clk, o_busy}, o_rd_data); end
    @(negedge i_clk); @(negedge i_clk); i_rst_n = 1'b1;
    do_write(16'h00A5, 16'h00A4, -1);
    e_rd = RB ? 16'h00A4 : 16'h0;
    checks++; if (obs_lat != LAT || n_da != 48 || da_sh !== {HDR, 16'h00A5}) begin
      failures++; $display("FAIL mid_after_frame lat=%0d n=%0d frame=%h", obs_lat, n_da, da_sh); end
    checks++; if (obs_rd !== e_rd || obs_cmp !== 1'b0) begin
      failures++; $display("FAIL mid_after_rb rd=%h cmp=%b exp rd=%h cmp=0", obs_rd, obs_cmp, e_rd); end
  endtask

  task automatic test_link_idle();
    checks++; if (overlap !== 1'b0) begin
      failures++; $display("FAIL link_overlap got=%b exp=0", overlap); end
    checks++; if (ad_cs_falls != (RB ? n_writes : 0)) begin
      failures++; $display("FAIL ad_frames got=%0d exp=%0d", ad_cs_falls, RB ? n_writes : 0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    test_link_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
